// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage redirect controller: arbitrates branch/jump/jump-register redirects,
// buffers one accepted target, issues it to IF and flags wrong-path fetches.
module fetch_redirect_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Stall,
   input  logic [31:0]      PC,
   input  logic             Br_Req,
   input  logic [31:0]      Br_Target,
   input  logic             J_Req,
   input  logic [25:0]      J_Index,
   input  logic             Jr_Req,
   input  logic [31:0]      Jr_Target,
   output logic             Branch_Jump,
   output logic [31:0]      PC_Update,
   output logic             Fetch_Valid,
   output logic             Conflict,
   output logic             Addr_Err,
   output logic             Drop,
   output logic [CNT_W-1:0] Redirect_Cnt
);

   localparam int unsigned FC_W = 3;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PEND  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [FC_W-1:0]   flush_cnt;
   logic [31:0]       p_target;
   logic              p_valid;
   logic [31:0]       j_target;
   logic [31:0]       win_target;
   logic              any_req;
   logic              multi_req;
   logic              aligned;
   logic              issue;
   logic              capture;
   logic              busy_drop;
   logic              unused_pc;

   assign unused_pc = ^PC[27:0];
   assign j_target  = {PC[31:28], J_Index, 2'b00};

   // Fixed priority: Jr > J > Br
   always_comb begin
      win_target = Br_Target;
      if (Jr_Req)
         win_target = Jr_Target;
      else if (J_Req)
         win_target = j_target;
   end

   assign any_req   = Jr_Req | J_Req | Br_Req;
   assign multi_req = (Jr_Req & J_Req) | (Jr_Req & Br_Req) | (J_Req & Br_Req);
   assign aligned   = (win_target[1:0] == 2'b00);
   assign p_valid   = (state == PEND);
   assign issue     = p_valid & ~Stall;
   // The buffer frees up in the same cycle it issues, so back-to-back capture is allowed
   assign capture   = any_req & aligned & (~p_valid | issue);
   assign busy_drop = any_req & aligned & p_valid & ~issue;

   always_ff @(posedge Clock) begin
      if (Reset)
         state <= RUN;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         RUN: begin
            if (capture)
               next_state = PEND;
         end
         PEND: begin
            if (capture)
               next_state = PEND;
            else if (issue)
               next_state = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
         end
         FLUSH: begin
            if (capture)
               next_state = PEND;
            else if (flush_cnt <= FC_W'(1))
               next_state = RUN;
         end
         default: next_state = RUN;
      endcase
   end

   always_comb begin
      Branch_Jump = 1'b0;
      Fetch_Valid = 1'b0;
      Branch_Jump = issue;
      Fetch_Valid = (state == RUN);
   end

   assign PC_Update = p_target;

   // Target buffer, flush window, issue counter and registered error pulses
   always_ff @(posedge Clock) begin
      if (Reset) begin
         p_target     <= 32'd0;
         flush_cnt    <= '0;
         Redirect_Cnt <= '0;
         Conflict     <= 1'b0;
         Addr_Err     <= 1'b0;
         Drop         <= 1'b0;
      end else begin
         if (capture)
            p_target <= win_target;
         if (issue)
            Redirect_Cnt <= Redirect_Cnt + CNT_W'(1);
         if (capture)
            flush_cnt <= '0;
         else if (issue)
            flush_cnt <= FC_W'(FLUSH_CYCLES);
         else if (flush_cnt != '0)
            flush_cnt <= flush_cnt - FC_W'(1);
         Conflict <= multi_req;
         Addr_Err <= any_req & ~aligned;
         Drop     <= busy_drop;
      end
   end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl; a second instance (CNT_W=2, no flush)
// covers counter wrap and the zero-length flush window.
module tb_fetch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [31:0] pc;
   logic        br_req;
   logic [31:0] br_target;
   logic        j_req;
   logic [25:0] j_index;
   logic        jr_req;
   logic [31:0] jr_target;

   logic        bj, fv, conflict, addr_err, drop;
   logic [31:0] pc_upd;
   logic [15:0] cnt;

   logic        w_bj, w_fv, w_conflict, w_addr_err, w_drop;
   logic [31:0] w_pc_upd;
   logic [1:0]  w_cnt;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   fetch_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut (
      .Clock(clk), .Reset(rst), .Stall(stall), .PC(pc),
      .Br_Req(br_req), .Br_Target(br_target), .J_Req(j_req), .J_Index(j_index),
      .Jr_Req(jr_req), .Jr_Target(jr_target),
      .Branch_Jump(bj), .PC_Update(pc_upd), .Fetch_Valid(fv),
      .Conflict(conflict), .Addr_Err(addr_err), .Drop(drop), .Redirect_Cnt(cnt)
   );

   fetch_redirect_ctrl #(.FLUSH_CYCLES(0), .CNT_W(2)) dut_w (
      .Clock(clk), .Reset(rst), .Stall(stall), .PC(pc),
      .Br_Req(br_req), .Br_Target(br_target), .J_Req(j_req), .J_Index(j_index),
      .Jr_Req(jr_req), .Jr_Target(jr_target),
      .Branch_Jump(w_bj), .PC_Update(w_pc_upd), .Fetch_Valid(w_fv),
      .Conflict(w_conflict), .Addr_Err(w_addr_err), .Drop(w_drop), .Redirect_Cnt(w_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      br_req = 1'b0;
      j_req  = 1'b0;
      jr_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; pc = 32'h0000_3000;
      clear_reqs();
      br_target = 32'd0; j_index = 26'd0; jr_target = 32'd0;
      tick(); tick();
      #1;
      vectors++; if (bj !== 1'b0) begin errors++; $display("FAIL reset_bj got=%b exp=0", bj); end
      vectors++; if (pc_upd !== 32'd0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc_upd); end
      vectors++; if (fv !== 1'b1) begin errors++; $display("FAIL reset_fv got=%b exp=1", fv); end
      vectors++; if ({conflict, addr_err, drop} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {conflict, addr_err, drop}); end
      vectors++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_branch();
      br_req = 1'b1; br_target = 32'h0000_3FFC;
      tick();
      clear_reqs(); #1;
      vectors++; if (bj !== 1'b1) begin errors++; $display("FAIL br_bj got=%b exp=1", bj); end
      vectors++; if (pc_upd !== 32'h0000_3FFC) begin errors++; $display("FAIL br_target got=%h exp=00003ffc", pc_upd); end
      vectors++; if (fv !== 1'b0) begin errors++; $display("FAIL br_fv_pend got=%b exp=0", fv); end
      tick();
      vectors++; if (bj !== 1'b0) begin errors++; $display("FAIL br_bj_after got=%b exp=0", bj); end
      vectors++; if (fv !== 1'b0) begin errors++; $display("FAIL br_fv_flush got=%b exp=0", fv); end
      vectors++; if (cnt !== 16'd1) begin errors++; $display("FAIL br_cnt got=%0d exp=1", cnt); end
      tick();
      vectors++; if (fv !== 1'b1) begin errors++; $display("FAIL br_fv_run got=%b exp=1", fv); end
   endtask

   task automatic test_collision();
      jr_req = 1'b1; jr_target = 32'h0000_3010;
      j_req  = 1'b1; j_index   = 26'h0000_123;
      br_req = 1'b1; br_target = 32'h0000_5000;
      tick();
      clear_reqs(); #1;
      vectors++; if (conflict !== 1'b1) begin errors++; $display("FAIL col_conflict got=%b exp=1", conflict); end
      vectors++; if (pc_upd !== 32'h0000_3010) begin errors++; $display("FAIL col_target got=%h exp=00003010", pc_upd); end
      vectors++; if (bj !== 1'b1) begin errors++; $display("FAIL col_bj got=%b exp=1", bj); end
      tick();
      vectors++; if (conflict !== 1'b0) begin errors++; $display("FAIL col_conflict_once got=%b exp=0", conflict); end
      vectors++; if (bj !== 1'b0) begin errors++; $display("FAIL col_single_issue got=%b exp=0", bj); end
      vectors++; if (cnt !== 16'd2) begin errors++; $display("FAIL col_cnt got=%0d exp=2", cnt); end
      tick();
   endtask

   task automatic test_jump_stall();
      pc = 32'h4000_3000; j_index = 26'h000_0C10; j_req = 1'b1;
      tick();
      clear_reqs(); stall = 1'b1; br_req = 1'b1; br_target = 32'h0000_5000; #1;
      vectors++; if (bj !== 1'b0) begin errors++; $display("FAIL js_bj_stall1 got=%b exp=0", bj); end
      vectors++; if (pc_upd !== 32'h4000_3040) begin errors++; $display("FAIL js_target got=%h exp=40003040", pc_upd); end
      tick();
      br_req = 1'b0; #1;
      vectors++; if (drop !== 1'b1) begin errors++; $display("FAIL js_drop got=%b exp=1", drop); end
      vectors++; if (bj !== 1'b0) begin errors++; $display("FAIL js_bj_stall2 got=%b exp=0", bj); end
      tick();
      vectors++; if (drop !== 1'b0) begin errors++; $display("FAIL js_drop_once got=%b exp=0", drop); end
      vectors++; if (pc_upd !== 32'h4000_3040) begin errors++; $display("FAIL js_target_held got=%h exp=40003040", pc_upd); end
      tick();
      stall = 1'b0; #1;
      vectors++; if (bj !== 1'b1) begin errors++; $display("FAIL js_bj_release got=%b exp=1", bj); end
      vectors++; if (pc_upd !== 32'h4000_3040) begin errors++; $display("FAIL js_target_issue got=%h exp=40003040", pc_upd); end
      tick();
      vectors++; if (cnt !== 16'd3) begin errors++; $display("FAIL js_cnt got=%0d exp=3", cnt); end
      vectors++; if (fv !== 1'b0) begin errors++; $display("FAIL js_fv_flush got=%b exp=0", fv); end
      tick();
      vectors++; if (fv !== 1'b1) begin errors++; $display("FAIL js_fv_run got=%b exp=1", fv); end
      pc = 32'h0000_3000;
   endtask

   task automatic test_misaligned();
      jr_req = 1'b1; jr_target = 32'h0000_3002; #1;
      vectors++; if (fv !== 1'b1) begin errors++; $display("FAIL mis_fv_pre got=%b exp=1", fv); end
      tick();
      clear_reqs(); #1;
      vectors++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mis_addr_err got=%b exp=1", addr_err); end
      vectors++; if (bj !== 1'b0) begin errors++; $display("FAIL mis_bj got=%b exp=0", bj); end
      vectors++; if (fv !== 1'b1) begin errors++; $display("FAIL mis_fv got=%b exp=1", fv); end
      tick();
      vectors++; if (addr_err !== 1'b0) begin errors++; $display("FAIL mis_addr_err_once got=%b exp=0", addr_err); end
      vectors++; if (cnt !== 16'd3) begin errors++; $display("FAIL mis_cnt got=%0d exp=3", cnt); end
   endtask

   task automatic test_back_to_back();
      br_req = 1'b1; br_target = 32'h0000_0100;
      tick();
      clear_reqs(); jr_req = 1'b1; jr_target = 32'h0000_0200; #1;
      vectors++; if (bj !== 1'b1) begin errors++; $display("FAIL b2b_bj1 got=%b exp=1", bj); end
      vectors++; if (pc_upd !== 32'h0000_0100) begin errors++; $display("FAIL b2b_t1 got=%h exp=00000100", pc_upd); end
      tick();
      clear_reqs(); #1;
      vectors++; if (bj !== 1'b1) begin errors++; $display("FAIL b2b_bj2 got=%b exp=1", bj); end
      vectors++; if (pc_upd !== 32'h0000_0200) begin errors++; $display("FAIL b2b_t2 got=%h exp=00000200", pc_upd); end
      vectors++; if (drop !== 1'b0) begin errors++; $display("FAIL b2b_drop got=%b exp=0", drop); end
      tick();
      vectors++; if (cnt !== 16'd5) begin errors++; $display("FAIL b2b_cnt got=%0d exp=5", cnt); end
      vectors++; if (fv !== 1'b0) begin errors++; $display("FAIL b2b_fv_flush got=%b exp=0", fv); end
      br_req = 1'b1; br_target = 32'h0000_0300;
      tick();
      clear_reqs(); #1;
      vectors++; if (bj !== 1'b1) begin errors++; $display("FAIL midflush_bj got=%b exp=1", bj); end
      vectors++; if (pc_upd !== 32'h0000_0300) begin errors++; $display("FAIL midflush_t got=%h exp=00000300", pc_upd); end
      tick();
      vectors++; if (cnt !== 16'd6) begin errors++; $display("FAIL midflush_cnt got=%0d exp=6", cnt); end
      tick();
      vectors++; if (fv !== 1'b1) begin errors++; $display("FAIL midflush_fv got=%b exp=1", fv); end
   endtask

   task automatic test_reset_mid();
      br_req = 1'b1; br_target = 32'h0000_0400;
      tick();
      clear_reqs(); stall = 1'b1; #1;
      vectors++; if (bj !== 1'b0) begin errors++; $display("FAIL rm_bj_stall got=%b exp=0", bj); end
      vectors++; if (fv !== 1'b0) begin errors++; $display("FAIL rm_fv_pend got=%b exp=0", fv); end
      rst = 1'b1;
      tick();
      rst = 1'b0; #1;
      vectors++; if (fv !== 1'b1) begin errors++; $display("FAIL rm_fv got=%b exp=1", fv); end
      vectors++; if (cnt !== 16'd0) begin errors++; $display("FAIL rm_cnt got=%0d exp=0", cnt); end
      vectors++; if (pc_upd !== 32'd0) begin errors++; $display("FAIL rm_pc got=%h exp=0", pc_upd); end
      stall = 1'b0; #1;
      vectors++; if (bj !== 1'b0) begin errors++; $display("FAIL rm_bj got=%b exp=0", bj); end
      tick();
      vectors++; if (bj !== 1'b0 || cnt !== 16'd0) begin errors++; $display("FAIL rm_no_issue bj=%b cnt=%0d exp bj=0 cnt=0", bj, cnt); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 5; i++) begin
         br_req = 1'b1; br_target = 32'h0000_0800 + 32'(i * 4);
         tick();
         clear_reqs(); #1;
         vectors++; if (w_bj !== 1'b1 || w_fv !== 1'b0) begin errors++; $display("FAIL wrap_issue%0d bj=%b fv=%b exp bj=1 fv=0", i, w_bj, w_fv); end
         tick();
         vectors++; if (w_fv !== 1'b1) begin errors++; $display("FAIL wrap_noflush%0d got=%b exp=1", i, w_fv); end
         vectors++; if (w_cnt !== 2'((i + 1) % 4)) begin errors++; $display("FAIL wrap_cnt%0d got=%0d exp=%0d", i, w_cnt, (i + 1) % 4); end
      end
      vectors++; if (cnt !== 16'd5) begin errors++; $display("FAIL wrap_main_cnt got=%0d exp=5", cnt); end
   endtask

   initial begin
      test_reset();
      test_single_branch();
      test_collision();
      test_jump_stall();
      test_misaligned();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
